hilo_muldiv_ctrl: RTL and testbench

- Sequencer that sits directly upstream of the iterative Divider and owns the architectural HI/LO registers of the multicycle MIPS core.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations from the control unit, latches the operands, and starts the Divider.
- Holds the Divider inputs stable, captures the quotient and remainder into LO/HI, and reports busy/done so the control FSM can stall MFHI/MFLO.

---
 rtl/hilo_muldiv_ctrl_pkg.sv | 25 ++
 rtl/hilo_muldiv_ctrl_if.sv | 32 +++
 rtl/hilo_muldiv_ctrl_regfile.sv | 25 ++
 rtl/hilo_muldiv_ctrl.sv | 154 +++++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
package hilo_muldiv_ctrl_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam int unsigned DIV_ITER = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MUL       = 3'd1,
    ST_DIV_START = 3'd2,
    ST_DIV_WAIT  = 3'd3,
    ST_DIV_CAP   = 3'd4
  } md_state_t;

  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// Request/response and Divider-side signals of the HI/LO sequencer.
interface hilo_muldiv_ctrl_if #(parameter int DATA_W = 32);

  logic              op_valid;
  logic [2:0]        op_code;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic              flush;
  logic              op_ready;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic [DATA_W-1:0] div_dividend;
  logic [DATA_W-1:0] div_divisor;
  logic              div_sign;
  logic              div_start;
  logic              div_busy;
  logic [DATA_W-1:0] div_q;
  logic [DATA_W-1:0] div_r;

  modport slave (
    input  op_valid, op_code, rs_val, rt_val, flush, div_busy, div_q, div_r,
    output op_ready, busy, done, hi, lo, div_dividend, div_divisor, div_sign, div_start
  );

  modport master (
    output op_valid, op_code, rs_val, rt_val, flush, div_busy, div_q, div_r,
    input  op_ready, busy, done, hi, lo, div_dividend, div_divisor, div_sign, div_start
  );

endinterface

// File: rtl/hilo_muldiv_ctrl_regfile.sv
// Architectural HI/LO register pair with independent write enables.
module hilo_regfile #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] hi_d,
  input  logic [DATA_W-1:0] lo_d,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else begin
      if (hi_we) hi <= hi_d;
      if (lo_we) lo <= lo_d;
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// MULT/DIV/MTHI/MTLO sequencer: inline multiplier, drives the iterative
// Divider and owns HI/LO.
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter bit DIV_ZERO_SKIP = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  hilo_muldiv_ctrl_if.slave bus
);

  md_state_t           state;
  logic [DATA_W-1:0]   mul_a, mul_b;
  logic                mul_signed;
  logic [DATA_W-1:0]   dvd, dvs;
  logic                dsign;
  logic                busy_q;
  logic                done_q;
  logic                start_q;

  logic                accept;
  logic                div_fall;
  logic [2*DATA_W-1:0] prod;
  logic                hi_we, lo_we;
  logic [DATA_W-1:0]   hi_d, lo_d;

  assign accept   = (state == ST_IDLE) && bus.op_valid && !bus.flush;
  assign div_fall = busy_q && !bus.div_busy;

  always_comb begin
    prod  = {{DATA_W{mul_signed & mul_a[DATA_W-1]}}, mul_a} *
            {{DATA_W{mul_signed & mul_b[DATA_W-1]}}, mul_b};
    hi_we = 1'b0;
    lo_we = 1'b0;
    hi_d  = bus.rs_val;
    lo_d  = bus.rs_val;
    unique case (state)
      ST_IDLE: begin
        if (accept && bus.op_code == MD_MTHI) hi_we = 1'b1;
        if (accept && bus.op_code == MD_MTLO) lo_we = 1'b1;
      end
      ST_MUL: begin
        if (!bus.flush) begin
          hi_we = 1'b1;
          lo_we = 1'b1;
          hi_d  = prod[2*DATA_W-1:DATA_W];
          lo_d  = prod[DATA_W-1:0];
        end
      end
      ST_DIV_WAIT: begin
        // Divider results are only valid in its ready cycle, so capture here
        // rather than one cycle later in DIV_CAP.
        if (!bus.flush && div_fall) begin
          hi_we = 1'b1;
          lo_we = 1'b1;
          hi_d  = bus.div_r;
          lo_d  = bus.div_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_signed <= 1'b0;
      dvd        <= '0;
      dvs        <= '0;
      dsign      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      start_q <= 1'b0;
      if (state != ST_IDLE && bus.flush) begin
        state <= ST_IDLE;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (accept) begin
              case (bus.op_code)
                MD_MULT, MD_MULTU: begin
                  mul_a      <= bus.rs_val;
                  mul_b      <= bus.rt_val;
                  mul_signed <= md_is_signed(bus.op_code);
                  state      <= ST_MUL;
                end
                MD_DIV, MD_DIVU: begin
                  dvd   <= bus.rs_val;
                  dvs   <= bus.rt_val;
                  dsign <= md_is_signed(bus.op_code);
                  if (DIV_ZERO_SKIP && bus.rt_val == '0) begin
                    done_q <= 1'b1;
                  end else begin
                    start_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state   <= ST_DIV_START;
                  end
                end
                MD_MTHI, MD_MTLO: done_q <= 1'b1;
                default: ;
              endcase
            end
          end
          ST_MUL: begin
            done_q <= 1'b1;
            state  <= ST_IDLE;
          end
          ST_DIV_START: begin
            busy_q <= 1'b0;
            state  <= ST_DIV_WAIT;
          end
          ST_DIV_WAIT: begin
            busy_q <= bus.div_busy;
            if (div_fall) begin
              done_q <= 1'b1;
              state  <= ST_DIV_CAP;
            end
          end
          ST_DIV_CAP: state <= ST_IDLE;
          default:    state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.op_ready     = (state == ST_IDLE);
  assign bus.busy         = (state != ST_IDLE);
  assign bus.done         = done_q;
  assign bus.div_start    = start_q;
  assign bus.div_dividend = dvd;
  assign bus.div_divisor  = dvs;
  assign bus.div_sign     = dsign;

  hilo_regfile #(
    .DATA_W(DATA_W)
  ) u_hilo (
    .clk   (clk),
    .rst_n (rst_n),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .hi_d  (hi_d),
    .lo_d  (lo_d),
    .hi    (bus.hi),
    .lo    (bus.lo)
  );

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl with a behavioural iterative Divider.
module tb_hilo_muldiv_ctrl;
  import hilo_muldiv_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  int unsigned cyc;
  int unsigned t_issue;
  int          checks;
  int          errors;

  hilo_muldiv_ctrl_if #(.DATA_W(32)) bus ();

  hilo_muldiv_ctrl #(
    .DATA_W        (32),
    .DIV_ZERO_SKIP (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Divider stub: 32 busy cycles after start, then one ready cycle.
  logic        dbusy, dready;
  int unsigned dcnt;
  logic        sa, sb;
  logic [31:0] ua, ub, uq, ur, mq, mr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbusy  <= 1'b0;
      dready <= 1'b0;
      dcnt   <= 0;
    end else begin
      dready <= 1'b0;
      if (bus.div_start) begin
        dbusy <= 1'b1;
        dcnt  <= DIV_ITER - 1;
      end else if (dbusy) begin
        if (dcnt == 0) begin
          dbusy  <= 1'b0;
          dready <= 1'b1;
        end else begin
          dcnt <= dcnt - 1;
        end
      end
    end
  end

  always_comb begin
    sa = bus.div_sign & bus.div_dividend[31];
    sb = bus.div_sign & bus.div_divisor[31];
    ua = sa ? -bus.div_dividend : bus.div_dividend;
    ub = sb ? -bus.div_divisor : bus.div_divisor;
    uq = '1;
    ur = ua;
    if (ub != 0) begin
      uq = ua / ub;
      ur = ua % ub;
    end
    mq = (sa ^ sb) ? -uq : uq;
    mr = sa ? -ur : ur;
  end

  // Garbage outside the ready cycle exposes a mistimed capture.
  assign bus.div_busy = dbusy;
  assign bus.div_q    = dready ? mq : 32'hDEADBEEF;
  assign bus.div_r    = dready ? mr : 32'hBAADF00D;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op_valid = 1'b1;
    bus.op_code  = op;
    bus.rs_val   = a;
    bus.rt_val   = b;
    t_issue      = cyc;
    @(negedge clk);
    bus.op_valid = 1'b0;
    bus.op_code  = 3'd7;
  endtask

  task automatic run_div(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic sgn,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int unsigned starts;
    int unsigned n;
    issue(op, a, b);
    starts = 0;
    n      = 0;
    while (bus.done !== 1'b1 && n < 60) begin
      if (bus.div_start === 1'b1) starts++;
      check({tag, "_dvd_stable"}, bus.div_dividend, a);
      check({tag, "_dvs_stable"}, bus.div_divisor, b);
      check({tag, "_sign_stable"}, bus.div_sign, sgn);
      bus.rs_val = $urandom;
      bus.rt_val = $urandom;
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, bus.done, 1'b1);
    check({tag, "_latency"}, cyc - t_issue, DIV_ITER + 3);
    check({tag, "_start_cnt"}, starts, 1);
    check({tag, "_dvd_cap"}, bus.div_dividend, a);
    check({tag, "_lo"}, bus.lo, exp_lo);
    check({tag, "_hi"}, bus.hi, exp_hi);
    @(negedge clk);
    check({tag, "_done_once"}, bus.done, 1'b0);
    check({tag, "_ready_after"}, bus.op_ready, 1'b1);
  endtask

  initial begin
    int unsigned n;
    checks       = 0;
    errors       = 0;
    cyc          = 0;
    rst_n        = 1'b0;
    bus.op_valid = 1'b0;
    bus.op_code  = 3'd7;
    bus.rs_val   = '0;
    bus.rt_val   = '0;
    bus.flush    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", bus.op_ready, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_start", bus.div_start, 1'b0);
    check("rst_hilo", {bus.hi, bus.lo}, 64'h0);
    check("rst_divin", {bus.div_sign, bus.div_dividend, bus.div_divisor}, 65'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // MULT -2 * 3
    issue(MD_MULT, 32'hFFFFFFFE, 32'd3);
    check("mult_busy", bus.busy, 1'b1);
    check("mult_ready", bus.op_ready, 1'b0);
    check("mult_done_early", bus.done, 1'b0);
    @(negedge clk);
    check("mult_done", bus.done, 1'b1);
    check("mult_latency", cyc - t_issue, 2);
    check("mult_hi", bus.hi, 32'hFFFFFFFF);
    check("mult_lo", bus.lo, 32'hFFFFFFFA);
    check("mult_idle", bus.busy, 1'b0);

    // MULTU same operands
    issue(MD_MULTU, 32'hFFFFFFFE, 32'd3);
    check("multu_done_early", bus.done, 1'b0);
    @(negedge clk);
    check("multu_done", bus.done, 1'b1);
    check("multu_hi", bus.hi, 32'h00000002);
    check("multu_lo", bus.lo, 32'hFFFFFFFA);
    @(negedge clk);
    check("multu_done_once", bus.done, 1'b0);

    run_div("div_m7_2", MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF);
    run_div("divu_100_7", MD_DIVU, 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
    run_div("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'h0);

    // MTHI / MTLO
    issue(MD_MTHI, 32'h1234, 32'h0);
    check("mthi_done", bus.done, 1'b1);
    check("mthi_hi", bus.hi, 32'h1234);
    check("mthi_busy", bus.busy, 1'b0);
    issue(MD_MTLO, 32'h5678, 32'h0);
    check("mtlo_done", bus.done, 1'b1);
    check("mtlo_lo", bus.lo, 32'h5678);
    check("mtlo_hi", bus.hi, 32'h1234);
    @(negedge clk);
    check("mtlo_done_once", bus.done, 1'b0);

    // DIVU by zero is skipped
    issue(MD_DIVU, 32'hAB, 32'h0);
    check("dz_done", bus.done, 1'b1);
    check("dz_start", bus.div_start, 1'b0);
    check("dz_busy", bus.busy, 1'b0);
    check("dz_hilo", {bus.hi, bus.lo}, 64'h00001234_00005678);
    check("dz_latch", {bus.div_dividend, bus.div_divisor}, 64'h000000AB_00000000);
    repeat (3) begin
      @(negedge clk);
      check("dz_no_start", bus.div_start, 1'b0);
      check("dz_no_done", bus.done, 1'b0);
    end

    // Flush ten cycles into a divide
    issue(MD_DIV, 32'd50, 32'd5);
    repeat (9) @(negedge clk);
    check("fl_still_busy", bus.busy, 1'b1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("fl_ready", bus.op_ready, 1'b1);
    check("fl_busy", bus.busy, 1'b0);
    check("fl_done", bus.done, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("fl_no_done", bus.done, 1'b0);
    end
    check("fl_hilo", {bus.hi, bus.lo}, 64'h00001234_00005678);
    run_div("divu_9_3", MD_DIVU, 32'd9, 32'd3, 1'b0, 32'd3, 32'd0);

    // flush in IDLE drops the op
    bus.flush = 1'b1;
    issue(MD_MTHI, 32'h7777, 32'h0);
    bus.flush = 1'b0;
    check("fl_idle_drop_hi", bus.hi, 32'h0);
    check("fl_idle_drop_done", bus.done, 1'b0);

    // MTHI held during a divide is ignored until op_ready returns
    bus.op_valid = 1'b1;
    bus.op_code  = MD_DIVU;
    bus.rs_val   = 32'd100;
    bus.rt_val   = 32'd7;
    t_issue      = cyc;
    @(negedge clk);
    bus.op_code  = MD_MTHI;
    bus.rs_val   = 32'hDEAD;
    bus.rt_val   = 32'h0;
    n = 0;
    while (bus.done !== 1'b1 && n < 60) begin
      check("hold_ready", bus.op_ready, 1'b0);
      check("hold_hi", bus.hi, 32'h0);
      @(negedge clk);
      n++;
    end
    check("hold_done", bus.done, 1'b1);
    check("hold_latency", cyc - t_issue, DIV_ITER + 3);
    check("hold_lo", bus.lo, 32'd14);
    check("hold_hi_cap", bus.hi, 32'd2);
    check("hold_ready_cap", bus.op_ready, 1'b0);
    @(negedge clk);
    check("hold_ready_back", bus.op_ready, 1'b1);
    check("hold_hi_pre", bus.hi, 32'd2);
    @(negedge clk);
    bus.op_valid = 1'b0;
    bus.op_code  = 3'd7;
    check("hold_mthi_hi", bus.hi, 32'hDEAD);
    check("hold_mthi_done", bus.done, 1'b1);
    check("hold_mthi_lo", bus.lo, 32'd14);

    // Reset mid-divide
    issue(MD_DIV, 32'hFFFFFFF9, 32'd2);
    repeat (8) @(negedge clk);
    check("mrst_busy_before", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mrst_hilo", {bus.hi, bus.lo}, 64'h0);
    check("mrst_ready", bus.op_ready, 1'b1);
    check("mrst_busy", bus.busy, 1'b0);
    check("mrst_start", bus.div_start, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Signed MULT of two large positives after reset
    issue(MD_MULT, 32'h7FFFFFFF, 32'h7FFFFFFF);
    @(negedge clk);
    check("mult_big_done", bus.done, 1'b1);
    check("mult_big_hilo", {bus.hi, bus.lo}, 64'h3FFFFFFF_00000001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
